// File: rtl/locking_rr_arbiter_if.sv
// Request/response bundle for locking_rr_arbiter: N request channels merged onto one output.
// "master" is the requester/downstream side, "slave" is the arbiter itself.
interface locking_rr_arbiter_if #(
   parameter int unsigned N_IN   = 3,
   parameter int unsigned DATA_W = 183,
   parameter int unsigned BEATS  = 4
);
   localparam int unsigned CHOSEN_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [N_IN-1:0]        io_in_valid;
   logic [N_IN-1:0]        io_in_ready;
   logic [N_IN-1:0]        io_in_multibeat;
   logic [N_IN*DATA_W-1:0] io_in_bits;
   logic                   io_out_valid;
   logic                   io_out_ready;
   logic [DATA_W-1:0]      io_out_bits;
   logic [CHOSEN_W-1:0]    io_chosen;
   logic                   io_locked;
   logic [BEAT_W-1:0]      io_beat;

   modport master (
      output io_in_valid, io_in_multibeat, io_in_bits, io_out_ready,
      input  io_in_ready, io_out_valid, io_out_bits, io_chosen, io_locked, io_beat
   );

   modport slave (
      input  io_in_valid, io_in_multibeat, io_in_bits, io_out_ready,
      output io_in_ready, io_out_valid, io_out_bits, io_chosen, io_locked, io_beat
   );
endinterface

// File: rtl/locking_rr_arbiter.sv
// N-input fixed-priority / round-robin arbiter that holds the grant on one input for the
// full length of a multi-beat message so bursts from different sources never interleave.
module locking_rr_arbiter #(
   parameter int unsigned N_IN    = 3,
   parameter int unsigned DATA_W  = 183,
   parameter int unsigned BEATS   = 4,
   parameter int unsigned RR_MODE = 1
) (
   input  logic                clk,
   input  logic                reset,
   locking_rr_arbiter_if.slave io
);
   localparam int unsigned CHOSEN_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CHOSEN_W-1:0] LAST_IDX  = CHOSEN_W'(N_IN - 1);
   localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);

   if (N_IN < 2) begin : g_bad_n_in
      $error("locking_rr_arbiter: N_IN must be at least 2");
   end
   if (BEATS < 1) begin : g_bad_beats
      $error("locking_rr_arbiter: BEATS must be at least 1");
   end

   typedef enum logic [0:0] {StOpen, StLocked} state_e;

   state_e              state_q, state_d;
   logic [CHOSEN_W-1:0] lock_idx_q, lock_idx_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [CHOSEN_W-1:0] last_grant_q, last_grant_d;

   logic [CHOSEN_W-1:0] rr_start;
   logic [CHOSEN_W-1:0] chosen;
   logic                fire;
   logic [DATA_W-1:0]   bits_arr [N_IN];

   for (genvar g = 0; g < N_IN; g++) begin : g_unpack
      assign bits_arr[g] = io.io_in_bits[g*DATA_W +: DATA_W];
   end

   assign rr_start = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;

   // Selection depends only on registered state and valids, never on io_out_ready.
   always_comb begin
      logic                found;
      logic [CHOSEN_W-1:0] idx;
      found  = 1'b0;
      idx    = '0;
      chosen = (RR_MODE != 0) ? rr_start : LAST_IDX;
      if (state_q == StLocked) begin
         chosen = lock_idx_q;
      end else begin
         for (int unsigned k = 0; k < N_IN; k++) begin
            if (RR_MODE != 0) begin
               idx = CHOSEN_W'((32'(rr_start) + k) % N_IN);
            end else begin
               idx = CHOSEN_W'(k);
            end
            if (!found && io.io_in_valid[idx]) begin
               chosen = idx;
               found  = 1'b1;
            end
         end
      end
   end

   assign fire            = io.io_out_valid & io.io_out_ready;
   assign io.io_out_valid = io.io_in_valid[chosen];
   assign io.io_out_bits  = bits_arr[chosen];
   assign io.io_chosen    = chosen;
   assign io.io_in_ready  = io.io_out_ready ? (N_IN'(1) << chosen) : '0;
   assign io.io_locked    = (state_q == StLocked);
   assign io.io_beat      = beat_q;

   always_comb begin
      state_d      = state_q;
      lock_idx_d   = lock_idx_q;
      beat_d       = beat_q;
      last_grant_d = last_grant_q;
      if (fire) begin
         unique case (state_q)
            StOpen: begin
               if (RR_MODE != 0) last_grant_d = chosen;
               if (io.io_in_multibeat[chosen] && (BEATS > 1)) begin
                  state_d    = StLocked;
                  lock_idx_d = chosen;
                  beat_d     = BEAT_W'(1);
               end
            end
            StLocked: begin
               // Multibeat flag is ignored here; every fire on the locked input is a beat.
               if (beat_q == LAST_BEAT) begin
                  state_d = StOpen;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
            default: state_d = StOpen;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StOpen;
         lock_idx_q   <= '0;
         beat_q       <= '0;
         last_grant_q <= LAST_IDX;
      end else begin
         state_q      <= state_d;
         lock_idx_q   <= lock_idx_d;
         beat_q       <= beat_d;
         last_grant_q <= last_grant_d;
      end
   end
endmodule

// File: tb/tb_locking_rr_arbiter.sv
// Directed bench for locking_rr_arbiter: fixed-priority, round-robin and BEATS=1 builds
// share one stimulus set; each scenario checks the build(s) it targets.
module tb_locking_rr_arbiter;
   localparam int unsigned N  = 3;
   localparam int unsigned DW = 183;
   localparam int FP = 0;
   localparam int RR = 1;
   localparam int B1 = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    valid = '0;
   logic [N-1:0]    mb = '0;
   logic            out_ready = 1'b0;
   logic [N*DW-1:0] bits = '0;

   int unsigned n_total = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   locking_rr_arbiter_if #(.N_IN(N), .DATA_W(DW), .BEATS(4)) bus_fp ();
   locking_rr_arbiter_if #(.N_IN(N), .DATA_W(DW), .BEATS(4)) bus_rr ();
   locking_rr_arbiter_if #(.N_IN(N), .DATA_W(DW), .BEATS(1)) bus_b1 ();

   assign bus_fp.io_in_valid = valid;
   assign bus_fp.io_in_multibeat = mb;
   assign bus_fp.io_in_bits = bits;
   assign bus_fp.io_out_ready = out_ready;
   assign bus_rr.io_in_valid = valid;
   assign bus_rr.io_in_multibeat = mb;
   assign bus_rr.io_in_bits = bits;
   assign bus_rr.io_out_ready = out_ready;
   assign bus_b1.io_in_valid = valid;
   assign bus_b1.io_in_multibeat = mb;
   assign bus_b1.io_in_bits = bits;
   assign bus_b1.io_out_ready = out_ready;

   locking_rr_arbiter #(.N_IN(N), .DATA_W(DW), .BEATS(4), .RR_MODE(0)) u_fp (
      .clk(clk), .reset(rst_n), .io(bus_fp)
   );
   locking_rr_arbiter #(.N_IN(N), .DATA_W(DW), .BEATS(4), .RR_MODE(1)) u_rr (
      .clk(clk), .reset(rst_n), .io(bus_rr)
   );
   locking_rr_arbiter #(.N_IN(N), .DATA_W(DW), .BEATS(1), .RR_MODE(1)) u_b1 (
      .clk(clk), .reset(rst_n), .io(bus_b1)
   );

   logic [1:0]    obs_chosen [3];
   logic [N-1:0]  obs_ready  [3];
   logic          obs_valid  [3];
   logic          obs_locked [3];
   logic [1:0]    obs_beat   [3];
   logic [DW-1:0] obs_bits   [3];

   assign obs_chosen[0] = bus_fp.io_chosen;
   assign obs_chosen[1] = bus_rr.io_chosen;
   assign obs_chosen[2] = bus_b1.io_chosen;
   assign obs_ready[0]  = bus_fp.io_in_ready;
   assign obs_ready[1]  = bus_rr.io_in_ready;
   assign obs_ready[2]  = bus_b1.io_in_ready;
   assign obs_valid[0]  = bus_fp.io_out_valid;
   assign obs_valid[1]  = bus_rr.io_out_valid;
   assign obs_valid[2]  = bus_b1.io_out_valid;
   assign obs_locked[0] = bus_fp.io_locked;
   assign obs_locked[1] = bus_rr.io_locked;
   assign obs_locked[2] = bus_b1.io_locked;
   assign obs_beat[0]   = bus_fp.io_beat;
   assign obs_beat[1]   = bus_rr.io_beat;
   assign obs_beat[2]   = 2'(bus_b1.io_beat);
   assign obs_bits[0]   = bus_fp.io_out_bits;
   assign obs_bits[1]   = bus_rr.io_out_bits;
   assign obs_bits[2]   = bus_b1.io_out_bits;

   function automatic logic [DW-1:0] pat(input int i);
      return (DW'(i + 1) << 176) | DW'(32'hBEEF_0000 + 32'(i) * 32'h111);
   endfunction

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = '0;
      mb = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic expect_grant(input string tag, input int d, input int idx, input bit vld);
      check({tag, ".chosen"}, obs_chosen[d], idx);
      check({tag, ".ready"}, obs_ready[d], out_ready ? (3'b001 << idx) : 3'b000);
      check({tag, ".valid"}, obs_valid[d], vld);
      if (vld) check({tag, ".bits"}, obs_bits[d], pat(idx));
   endtask

   task automatic expect_lock(input string tag, input int d, input bit lk, input int beat);
      check({tag, ".locked"}, obs_locked[d], lk);
      check({tag, ".beat"}, obs_beat[d], beat);
   endtask

   // Three remaining beats of a locked burst on idx, then the first unlocked grant.
   task automatic burst_tail(input string tag, input int d, input int idx, input int nxt);
      for (int b = 1; b <= 3; b++) begin
         #1;
         expect_lock($sformatf("%s.b%0d", tag, b), d, 1'b1, b);
         expect_grant($sformatf("%s.b%0d", tag, b), d, idx, 1'b1);
         tick();
      end
      #1;
      expect_lock({tag, ".after"}, d, 1'b0, 0);
      expect_grant({tag, ".after"}, d, nxt, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < int'(N); i++) bits[i*DW +: DW] = pat(i);

      // Reset state: RR pointer starts at N_IN-1 so round-robin begins at 0.
      do_reset();
      out_ready = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) expect_lock($sformatf("rst.d%0d", d), d, 1'b0, 0);
      expect_grant("rst.fp", FP, 2, 1'b0);
      expect_grant("rst.rr", RR, 0, 1'b0);

      // Fixed priority.
      valid = 3'b111;
      for (int c = 0; c < 3; c++) begin
         #1;
         expect_grant($sformatf("fp.all.c%0d", c), FP, 0, 1'b1);
         tick();
      end
      valid = 3'b110;
      #1;
      expect_grant("fp.drop0", FP, 1, 1'b1);
      tick();
      valid = 3'b000;
      #1;
      expect_grant("fp.idle", FP, 2, 1'b0);

      // Round robin, single-beat.
      do_reset();
      out_ready = 1'b1;
      valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         expect_grant($sformatf("rr.c%0d", c), RR, c % 3, 1'b1);
         tick();
      end

      // Burst lock, round robin: move pointer to 0, then lock on input 1.
      do_reset();
      out_ready = 1'b1;
      valid = 3'b001;
      #1;
      expect_grant("rrb.pre", RR, 0, 1'b1);
      tick();
      valid = 3'b111;
      mb = 3'b010;
      #1;
      expect_grant("rrb.lock", RR, 1, 1'b1);
      expect_lock("rrb.lock", RR, 1'b0, 0);
      tick();
      mb = 3'b111;
      burst_tail("rrb", RR, 1, 2);

      // Burst lock, fixed priority.
      do_reset();
      out_ready = 1'b1;
      valid = 3'b010;
      mb = 3'b010;
      #1;
      expect_grant("fpb.lock", FP, 1, 1'b1);
      tick();
      valid = 3'b111;
      mb = 3'b111;
      burst_tail("fpb", FP, 1, 0);

      // Backpressure and source stall mid-burst on input 2.
      do_reset();
      out_ready = 1'b1;
      valid = 3'b100;
      mb = 3'b100;
      #1;
      expect_grant("bp.lock.fp", FP, 2, 1'b1);
      expect_grant("bp.lock.rr", RR, 2, 1'b1);
      tick();
      tick();
      valid = 3'b111;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            expect_grant($sformatf("bp.stall.d%0d.c%0d", d, c), d, 2, 1'b1);
            expect_lock($sformatf("bp.stall.d%0d.c%0d", d, c), d, 1'b1, 2);
         end
         tick();
      end
      out_ready = 1'b1;
      valid = 3'b011;
      for (int c = 0; c < 3; c++) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            expect_grant($sformatf("bp.srcidle.d%0d.c%0d", d, c), d, 2, 1'b0);
            expect_lock($sformatf("bp.srcidle.d%0d.c%0d", d, c), d, 1'b1, 2);
         end
         tick();
      end
      valid = 3'b111;
      tick();
      #1;
      for (int d = 0; d < 2; d++) expect_lock($sformatf("bp.b3.d%0d", d), d, 1'b1, 3);
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
         expect_lock($sformatf("bp.done.d%0d", d), d, 1'b0, 0);
         expect_grant($sformatf("bp.done.d%0d", d), d, 0, 1'b1);
      end

      // Reset asserted mid-burst abandons the lock.
      do_reset();
      out_ready = 1'b1;
      valid = 3'b100;
      mb = 3'b111;
      tick();
      tick();
      tick();
      #1;
      expect_lock("rstb.pre", RR, 1'b1, 3);
      valid = 3'b111;
      rst_n = 1'b0;
      #1;
      expect_lock("rstb.held", RR, 1'b0, 0);
      expect_grant("rstb.held.rr", RR, 0, 1'b1);
      expect_grant("rstb.held.fp", FP, 0, 1'b1);
      tick();
      rst_n = 1'b1;
      #1;
      expect_grant("rstb.rel", RR, 0, 1'b1);
      tick();
      #1;
      expect_lock("rstb.relock", RR, 1'b1, 1);
      expect_grant("rstb.relock", RR, 0, 1'b1);

      // BEATS=1 build never locks.
      do_reset();
      out_ready = 1'b1;
      valid = 3'b111;
      mb = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         expect_grant($sformatf("b1.c%0d", c), B1, c % 3, 1'b1);
         expect_lock($sformatf("b1.c%0d", c), B1, 1'b0, 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
